// File: rtl/uart_pkg.sv
// Shared UART definitions for the stdout transmitter and the stdin receiver.
// Holds the frame state type and the line-level constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int         UART_DATA_BITS  = 8;
    localparam logic       UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/stdout_uart_tx_if.sv
// CPU-to-UART stdout bundle: byte push request, back-pressure and line status.
// The master is the CPU pipeline, the slave is the transmitter.
interface stdout_uart_tx_if;
    import uart_pkg::*;

    logic                      stdout_write_enable;
    logic [UART_DATA_BITS-1:0] stdout_data;
    logic                      stall;
    logic                      txd;
    logic                      busy;

    modport master (
        output stdout_write_enable,
        output stdout_data,
        input  stall,
        input  txd,
        input  busy
    );

    modport slave (
        input  stdout_write_enable,
        input  stdout_data,
        output stall,
        output txd,
        output busy
    );

endinterface

// File: rtl/stdout_uart_tx_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data.
// Pushes while full and pops while empty are dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/stdout_uart_tx.sv
// CPU stdout sink: buffers bytes in a FIFO and sends them as 8N1 UART frames.
// Define STDOUT_TX_PARITY_EN to insert an even parity bit (8E1 frames).
module stdout_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic             clk,
    input  logic             rst,
    stdout_uart_tx_if.slave  bus
);

    localparam int CTR_W = $clog2(CLK_PER_BIT);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(CLK_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

    tx_state_t                 state_q, state_d;
    logic [CTR_W-1:0]          ctr_q, ctr_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      txd_q, txd_d;
`ifdef STDOUT_TX_PARITY_EN
    logic                      par_q, par_d;
`endif

    logic                      push;
    logic                      pop;
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CNT_W-1:0]          fifo_count;
    logic                      bit_end;

    assign push      = bus.stdout_write_enable && !fifo_full;
    assign bit_end   = (ctr_q == '0);
    assign bus.stall = fifo_full;
    assign bus.txd   = txd_q;
    assign bus.busy  = (fifo_count != '0) || (state_q != IDLE);

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.stdout_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Frame sequencer: next state, baud countdown, shifter and next line level.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = UART_IDLE_LEVEL;
        pop     = 1'b0;
`ifdef STDOUT_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    ctr_d   = CTR_LOAD;
                    bit_d   = '0;
                    state_d = START;
`ifdef STDOUT_TX_PARITY_EN
                    par_d   = ^fifo_dout;
`endif
                end
            end
            START: begin
                txd_d = 1'b0;
                if (bit_end) begin
                    ctr_d   = CTR_LOAD;
                    state_d = DATA;
                end else begin
                    ctr_d = ctr_q - 1'b1;
                end
            end
            DATA: begin
                txd_d = shift_q[0];
                if (bit_end) begin
                    ctr_d   = CTR_LOAD;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
`ifdef STDOUT_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    ctr_d = ctr_q - 1'b1;
                end
            end
`ifdef STDOUT_TX_PARITY_EN
            PARITY: begin
                txd_d = par_q;
                if (bit_end) begin
                    ctr_d   = CTR_LOAD;
                    state_d = STOP;
                end else begin
                    ctr_d = ctr_q - 1'b1;
                end
            end
`endif
            STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        ctr_d   = CTR_LOAD;
                        bit_d   = '0;
                        state_d = START;
`ifdef STDOUT_TX_PARITY_EN
                        par_d   = ^fifo_dout;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ctr_d = ctr_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers; txd is registered so the pin never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= UART_IDLE_LEVEL;
`ifdef STDOUT_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
`ifdef STDOUT_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Randomised bench for stdout_uart_tx against a queue-and-frame-timer model.
// Honours STDOUT_TX_PARITY_EN for 8E1 frames.
module tb_stdout_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef STDOUT_TX_PARITY_EN
    localparam int FLEN = 11;
    localparam logic [10:0] EXP41 = 11'b10010000010;
`else
    localparam int FLEN = 10;
    localparam logic [10:0] EXP41 = 11'b01010000010;
`endif

    logic clk = 1'b0;
    logic rst;

    stdout_uart_tx_if bus ();

    stdout_uart_tx #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_q [$];
    logic       m_act;
    int         m_pos;
    logic [7:0] m_cur;
    logic       m_txd;
    logic       txd_log [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef STDOUT_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_act = 1'b0;
        m_pos = 0;
        m_cur = '0;
        m_txd = 1'b1;
    endtask

    // One clock edge of the reference: line level from the pre-edge frame
    // position, then frame advance/pop, then the push decided by pre-edge fill.
    task automatic model_edge(input logic we, input logic [7:0] d);
        logic was_full;
        m_txd    = m_act ? fbit(m_cur, m_pos / CPB) : 1'b1;
        was_full = (m_q.size() == DEPTH);
        if (!m_act) begin
            if (m_q.size() > 0) begin
                m_cur = m_q.pop_front();
                m_act = 1'b1;
                m_pos = 0;
            end
        end else if (m_pos == FLEN * CPB - 1) begin
            if (m_q.size() > 0) begin
                m_cur = m_q.pop_front();
                m_pos = 0;
            end else begin
                m_act = 1'b0;
            end
        end else begin
            m_pos++;
        end
        if (we && !was_full) m_q.push_back(d);
    endtask

    task automatic cycle(input logic we, input logic [7:0] d);
        bus.stdout_write_enable = we;
        bus.stdout_data         = d;
        @(posedge clk);
        model_edge(we, d);
        #1;
        txd_log.push_back(bus.txd);
        chk("txd", 32'(bus.txd), 32'(m_txd));
        chk("stall", 32'(bus.stall), 32'(m_q.size() == DEPTH));
        chk("busy", 32'(bus.busy), 32'(m_q.size() != 0 || m_act));
    endtask

    initial begin
        logic [10:0] seq;
        rst = 1'b1;
        bus.stdout_write_enable = 1'b0;
        bus.stdout_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", 32'(bus.txd), 32'd1);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        txd_log.delete();
        cycle(1'b1, 8'h41);
        repeat (FLEN * CPB + 6) cycle(1'b0, 8'h00);
        seq = '0;
        for (int k = 0; k < FLEN; k++) seq[k] = txd_log[3 + 4 * k];
        chk("lat_hi", 32'(txd_log[1]), 32'd1);
        chk("lat_lo", 32'(txd_log[2]), 32'd0);
        chk("frame41", 32'(seq), 32'(EXP41));
        chk("busy_end", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i));
        repeat (6 * FLEN * CPB) cycle(1'b0, 8'h00);

        txd_log.delete();
        cycle(1'b1, 8'h55);
        cycle(1'b1, 8'hAA);
        repeat (2 * FLEN * CPB + 6) cycle(1'b0, 8'h00);
        chk("b2b_stop", 32'(txd_log[1 + FLEN * CPB]), 32'd1);
        chk("b2b_start", 32'(txd_log[2 + FLEN * CPB]), 32'd0);

        cycle(1'b1, 8'h07);
        cycle(1'b1, 8'h03);
        repeat (150) cycle(1'b1, 8'($urandom));
        repeat (800) cycle(($urandom % 6) == 0, 8'($urandom));

        cycle(1'b1, 8'hC3);
        repeat (15) cycle(1'b0, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_txd", 32'(bus.txd), 32'd1);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_stall", 32'(bus.stall), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("hold_txd", 32'(bus.txd), 32'd1);
        rst = 1'b0;
        repeat (5) cycle(1'b0, 8'h00);
        repeat (40) cycle(($urandom % 3) == 0, 8'($urandom));
        repeat (8 * FLEN * CPB) cycle(1'b0, 8'h00);
        chk("final_busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
